// File: rtl/mc_pkg.sv
// Shared opcodes, ALU operation codes, FSM state encoding and control-strobe bundle
// for the multicycle controller.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_BNEAL = 6'b101101;
  localparam logic [5:0] OP_BALV  = 6'b100001;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExecR   = 4'd2,
    StRWb     = 4'd3,
    StExecI   = 4'd4,
    StIWb     = 4'd5,
    StMemAddr = 4'd6,
    StMemRd   = 4'd7,
    StMemWb   = 4'd8,
    StMemWr   = 4'd9,
    StBranch  = 4'd10,
    StHalt    = 4'd11
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       iord;
    logic       mem_req;
    logic       mem_we;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic [1:0] pcsource;
    logic       link;
    logic       reg_31;
    logic       b_invert;
    logic       balv_s;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_out_decode.sv
// Per-state control strobe decode for the multicycle controller.
// EXT_BRANCH_EN adds the bneal/balv link variants in BRANCH, selected by the latched opcode.
module mc_out_decode
  import mc_pkg::*;
(
  input  state_e     i_state,
`ifdef EXT_BRANCH_EN
  input  logic [5:0] i_opcode,
`endif
  input  logic       i_mem_ready,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    unique case (i_state)
      StFetch: begin
        o_ctrl.mem_req  = 1'b1;
        o_ctrl.alusrcb  = 2'b01;
        o_ctrl.aluop    = ALUOP_ADD;
        o_ctrl.ir_write = i_mem_ready;
        o_ctrl.pc_write = i_mem_ready;
      end
      StDecode: begin
        o_ctrl.alusrcb = 2'b11;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      StExecR: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = 2'b00;
        o_ctrl.aluop   = ALUOP_FUNCT;
      end
      StRWb: begin
        o_ctrl.regdst   = 1'b1;
        o_ctrl.regwrite = 1'b1;
      end
      StExecI: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = 2'b10;
        o_ctrl.aluop   = ALUOP_AND;
      end
      StIWb: begin
        o_ctrl.regwrite = 1'b1;
      end
      StMemAddr: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = 2'b10;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      StMemRd: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.iord    = 1'b1;
      end
      StMemWb: begin
        o_ctrl.memtoreg = 1'b1;
        o_ctrl.regwrite = 1'b1;
      end
      StMemWr: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.iord    = 1'b1;
        o_ctrl.mem_we  = 1'b1;
      end
      StBranch: begin
        o_ctrl.alusrca       = 1'b1;
        o_ctrl.alusrcb       = 2'b00;
        o_ctrl.aluop         = ALUOP_SUB;
        o_ctrl.pcsource      = 2'b01;
        o_ctrl.pc_write_cond = 1'b1;
`ifdef EXT_BRANCH_EN
        if (i_opcode == OP_BNEAL || i_opcode == OP_BALV) begin
          o_ctrl.link     = 1'b1;
          o_ctrl.reg_31   = 1'b1;
          o_ctrl.regwrite = 1'b1;
          o_ctrl.b_invert = (i_opcode == OP_BNEAL);
          o_ctrl.balv_s   = (i_opcode == OP_BALV);
        end
`endif
      end
      StHalt: begin
        o_ctrl.illegal = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore multicycle CPU controller: state register, next-state logic and reset gating.
// EXT_BRANCH_EN enables the bneal/balv branch-and-link opcodes.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_req,
  output logic       mem_we,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic [1:0] pcsource,
  output logic       link,
  output logic       reg_31,
  output logic       b_invert,
  output logic       balv_s,
  output logic       illegal,
  output logic [3:0] state
);
  import mc_pkg::*;

  state_e r_state;
  state_e w_state_next;
  ctrl_t  w_ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_next;
    end
  end

`ifdef EXT_BRANCH_EN
  // Branch variant is chosen from the opcode seen in DECODE, not the live IR.
  logic [5:0] r_opcode;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_opcode <= '0;
    end else if (r_state == StDecode) begin
      r_opcode <= opcode;
    end
  end
`endif

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StFetch:   if (mem_ready) w_state_next = StDecode;
      StDecode: begin
        case (opcode)
          OP_RTYPE:     w_state_next = StExecR;
          OP_LW, OP_SW: w_state_next = StMemAddr;
          OP_BEQ:       w_state_next = StBranch;
          OP_ANDI:      w_state_next = StExecI;
`ifdef EXT_BRANCH_EN
          OP_BNEAL, OP_BALV: w_state_next = StBranch;
`endif
          default:      w_state_next = StHalt;
        endcase
      end
      StExecR:   w_state_next = StRWb;
      StRWb:     w_state_next = StFetch;
      StExecI:   w_state_next = StIWb;
      StIWb:     w_state_next = StFetch;
      StMemAddr: w_state_next = (opcode == OP_LW) ? StMemRd : StMemWr;
      StMemRd:   if (mem_ready) w_state_next = StMemWb;
      StMemWb:   w_state_next = StFetch;
      StMemWr:   if (mem_ready) w_state_next = StFetch;
      StBranch:  w_state_next = StFetch;
      StHalt:    w_state_next = StHalt;
      default:   w_state_next = StFetch;
    endcase
  end

  mc_out_decode u_out_decode (
    .i_state     (r_state),
`ifdef EXT_BRANCH_EN
    .i_opcode    (r_opcode),
`endif
    .i_mem_ready (mem_ready),
    .o_ctrl      (w_ctrl)
  );

  // Architectural write strobes are suppressed while reset is applied.
  assign pc_write      = w_ctrl.pc_write & ~reset;
  assign pc_write_cond = w_ctrl.pc_write_cond & ~reset;
  assign ir_write      = w_ctrl.ir_write & ~reset;
  assign mem_we        = w_ctrl.mem_we & ~reset;
  assign regwrite      = w_ctrl.regwrite & ~reset;

  assign iord     = w_ctrl.iord;
  assign mem_req  = w_ctrl.mem_req;
  assign alusrca  = w_ctrl.alusrca;
  assign alusrcb  = w_ctrl.alusrcb;
  assign aluop    = w_ctrl.aluop;
  assign regdst   = w_ctrl.regdst;
  assign memtoreg = w_ctrl.memtoreg;
  assign pcsource = w_ctrl.pcsource;
  assign link     = w_ctrl.link;
  assign reg_31   = w_ctrl.reg_31;
  assign b_invert = w_ctrl.b_invert;
  assign balv_s   = w_ctrl.balv_s;
  assign illegal  = w_ctrl.illegal;
  assign state    = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control; covers both EXT_BRANCH_EN builds.
module tb_multicycle_control;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_R_WB = 4'd3;
  localparam logic [3:0] S_EXEC_I = 4'd4, S_I_WB = 4'd5, S_MEM_ADDR = 4'd6, S_MEM_RD = 4'd7;
  localparam logic [3:0] S_MEM_WB = 4'd8, S_MEM_WR = 4'd9, S_BRANCH = 4'd10, S_HALT = 4'd11;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, ir_write, iord, mem_req, mem_we, alusrca;
  logic [1:0] alusrcb, aluop, pcsource;
  logic       regdst, memtoreg, regwrite, link, reg_31, b_invert, balv_s, illegal;
  logic [3:0] state;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_control dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .ir_write      (ir_write),
    .iord          (iord),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .alusrca       (alusrca),
    .alusrcb       (alusrcb),
    .aluop         (aluop),
    .regdst        (regdst),
    .memtoreg      (memtoreg),
    .regwrite      (regwrite),
    .pcsource      (pcsource),
    .link          (link),
    .reg_31        (reg_31),
    .b_invert      (b_invert),
    .balv_s        (balv_s),
    .illegal       (illegal),
    .state         (state)
  );

  always #5 clk = ~clk;

  // Inputs are changed 2 time units after the rising edge; checks follow 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1; opcode = 6'b000000; mem_ready = 1'b0;
    cyc(); cyc();
    #1;
    n_cmp++;
    if (state !== S_FETCH) begin
      n_err++; $display("FAIL reset_state: got %0d want %0d", state, S_FETCH);
    end
    n_cmp++;
    if ({regwrite, mem_we, pc_write, pc_write_cond, ir_write} !== 5'b0) begin
      n_err++; $display("FAIL reset_strobes: got %b want 00000",
                        {regwrite, mem_we, pc_write, pc_write_cond, ir_write});
    end
    reset = 1'b0;
    cyc();
    #1;
    n_cmp++;
    if ({state, ir_write, pc_write, mem_req} !== {S_FETCH, 3'b001}) begin
      n_err++; $display("FAIL fetch_wait: got st=%0d ir=%b pc=%b req=%b want st=0 ir=0 pc=0 req=1",
                        state, ir_write, pc_write, mem_req);
    end
    mem_ready = 1'b1;
    #1;
    n_cmp++;
    if ({ir_write, pc_write} !== 2'b11) begin
      n_err++; $display("FAIL fetch_ready: got ir=%b pc=%b want 1 1", ir_write, pc_write);
    end
  endtask

  task automatic test_rtype();
    logic [3:0] exp_st [4];
    exp_st = '{S_FETCH, S_DECODE, S_EXEC_R, S_R_WB};
    opcode = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      if (i >= 2) opcode = 6'b111111;
      #1;
      n_cmp++;
      if (state !== exp_st[i]) begin
        n_err++; $display("FAIL rtype_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
      end
      n_cmp++;
      if (regwrite !== (i == 3)) begin
        n_err++; $display("FAIL rtype_regwrite[%0d]: got %b want %b", i, regwrite, (i == 3));
      end
      if (i == 0) begin
        n_cmp++;
        if ({mem_req, iord, alusrca, alusrcb, aluop, pcsource} !== 9'b1_0_0_01_00_00) begin
          n_err++; $display("FAIL fetch_ctrl: got %b want 100010000",
                            {mem_req, iord, alusrca, alusrcb, aluop, pcsource});
        end
      end
      if (i == 1) begin
        n_cmp++;
        if ({alusrca, alusrcb, aluop} !== 5'b0_11_00) begin
          n_err++; $display("FAIL decode_ctrl: got %b want 01100", {alusrca, alusrcb, aluop});
        end
      end
      if (i == 2) begin
        n_cmp++;
        if ({alusrca, alusrcb, aluop} !== 5'b1_00_10) begin
          n_err++; $display("FAIL exec_r_ctrl: got %b want 10010", {alusrca, alusrcb, aluop});
        end
      end
      if (i == 3) begin
        n_cmp++;
        if ({regdst, memtoreg} !== 2'b10) begin
          n_err++; $display("FAIL r_wb_ctrl: got %b want 10", {regdst, memtoreg});
        end
      end
      cyc();
    end
    #1;
    n_cmp++;
    if (state !== S_FETCH) begin
      n_err++; $display("FAIL rtype_latency: got %0d want %0d", state, S_FETCH);
    end
  endtask

  task automatic test_lw_wait();
    logic [3:0] exp_st [7];
    logic       mr     [7];
    exp_st = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_RD, S_MEM_RD, S_MEM_WB};
    mr     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = 6'b100011;
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr[i];
      #1;
      n_cmp++;
      if (state !== exp_st[i]) begin
        n_err++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
      end
      if (i == 2) begin
        n_cmp++;
        if ({alusrca, alusrcb, aluop} !== 5'b1_10_00) begin
          n_err++; $display("FAIL mem_addr_ctrl: got %b want 11000", {alusrca, alusrcb, aluop});
        end
      end
      if (i >= 3 && i <= 5) begin
        n_cmp++;
        if ({mem_req, iord, mem_we, regwrite} !== 4'b1100) begin
          n_err++; $display("FAIL mem_rd_ctrl[%0d]: got %b want 1100", i,
                            {mem_req, iord, mem_we, regwrite});
        end
      end
      if (i == 6) begin
        n_cmp++;
        if ({regdst, memtoreg, regwrite} !== 3'b011) begin
          n_err++; $display("FAIL mem_wb_ctrl: got %b want 011", {regdst, memtoreg, regwrite});
        end
      end
      cyc();
    end
    mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (state !== S_FETCH) begin
      n_err++; $display("FAIL lw_latency: got %0d want %0d", state, S_FETCH);
    end
  endtask

  task automatic test_sw();
    logic [3:0] exp_st [4];
    exp_st = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_WR};
    opcode = 6'b101011;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      #1;
      n_cmp++;
      if (state !== exp_st[i]) begin
        n_err++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
      end
      n_cmp++;
      if ({regwrite, mem_we} !== {1'b0, (i == 3)}) begin
        n_err++; $display("FAIL sw_strobes[%0d]: got rw=%b we=%b want rw=0 we=%b", i,
                          regwrite, mem_we, (i == 3));
      end
      if (i == 3) begin
        n_cmp++;
        if ({mem_req, iord} !== 2'b11) begin
          n_err++; $display("FAIL mem_wr_ctrl: got %b want 11", {mem_req, iord});
        end
      end
      cyc();
    end
    #1;
    n_cmp++;
    if (state !== S_FETCH) begin
      n_err++; $display("FAIL sw_latency: got %0d want %0d", state, S_FETCH);
    end
  endtask

  task automatic test_andi();
    logic [3:0] exp_st [4];
    exp_st = '{S_FETCH, S_DECODE, S_EXEC_I, S_I_WB};
    opcode = 6'b001100;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      #1;
      n_cmp++;
      if (state !== exp_st[i]) begin
        n_err++; $display("FAIL andi_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
      end
      if (i == 2) begin
        n_cmp++;
        if ({alusrca, alusrcb, aluop, regwrite} !== 6'b1_10_11_0) begin
          n_err++; $display("FAIL exec_i_ctrl: got %b want 110110",
                            {alusrca, alusrcb, aluop, regwrite});
        end
      end
      if (i == 3) begin
        n_cmp++;
        if ({regdst, memtoreg, regwrite} !== 3'b001) begin
          n_err++; $display("FAIL i_wb_ctrl: got %b want 001", {regdst, memtoreg, regwrite});
        end
      end
      cyc();
    end
    #1;
    n_cmp++;
    if (state !== S_FETCH) begin
      n_err++; $display("FAIL andi_latency: got %0d want %0d", state, S_FETCH);
    end
  endtask

  task automatic test_beq();
    logic [3:0] exp_st [3];
    exp_st = '{S_FETCH, S_DECODE, S_BRANCH};
    opcode = 6'b000100;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1;
      #1;
      n_cmp++;
      if (state !== exp_st[i]) begin
        n_err++; $display("FAIL beq_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
      end
      if (i == 2) begin
        n_cmp++;
        if ({alusrca, alusrcb, aluop, pcsource, pc_write_cond, regwrite, link, pc_write}
            !== 11'b1_00_01_01_1_0_0_0) begin
          n_err++; $display("FAIL beq_ctrl: got %b want 10001011000",
                            {alusrca, alusrcb, aluop, pcsource, pc_write_cond, regwrite, link,
                             pc_write});
        end
      end
      cyc();
    end
    #1;
    n_cmp++;
    if (state !== S_FETCH) begin
      n_err++; $display("FAIL beq_latency: got %0d want %0d", state, S_FETCH);
    end
  endtask

  // exp_ext is {link, reg_31, regwrite, b_invert, balv_s, pc_write_cond} in BRANCH.
  task automatic test_ext_branch(input logic [5:0] op, input logic [5:0] exp_ext);
    opcode = op;
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1'b1;
      #1;
      n_cmp++;
      if (state !== ((i == 0) ? S_FETCH : S_DECODE)) begin
        n_err++; $display("FAIL ext_%b_state[%0d]: got %0d", op, i, state);
      end
      cyc();
    end
    opcode = 6'b000100;
    #1;
`ifdef EXT_BRANCH_EN
    n_cmp++;
    if (state !== S_BRANCH) begin
      n_err++; $display("FAIL ext_%b_branch: got %0d want %0d", op, state, S_BRANCH);
    end
    n_cmp++;
    if ({link, reg_31, regwrite, b_invert, balv_s, pc_write_cond} !== exp_ext) begin
      n_err++; $display("FAIL ext_%b_ctrl: got %b want %b", op,
                        {link, reg_31, regwrite, b_invert, balv_s, pc_write_cond}, exp_ext);
    end
    cyc();
    #1;
    n_cmp++;
    if (state !== S_FETCH) begin
      n_err++; $display("FAIL ext_%b_latency: got %0d want %0d", op, state, S_FETCH);
    end
`else
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({state, illegal, link, reg_31, b_invert, balv_s, regwrite} !== {S_HALT, 6'b100000})
      begin
        n_err++; $display("FAIL ext_%b_halt[%0d]: got st=%0d ill=%b ext=%b want st=11 ill=1 ext=%b",
                          op, i, state, illegal, {link, reg_31, b_invert, balv_s, regwrite},
                          exp_ext[0] & 1'b0);
      end
      cyc();
      #1;
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
`endif
  endtask

  task automatic test_halt();
    opcode = 6'b111111;
    mem_ready = 1'b1;
    cyc(); cyc();
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++;
      if ({state, illegal, mem_req, regwrite, pc_write, ir_write} !== {S_HALT, 5'b10000}) begin
        n_err++; $display("FAIL halt_hold[%0d]: got st=%0d ill=%b req=%b rw=%b want st=11 1 0 0",
                          i, state, illegal, mem_req, regwrite);
      end
      cyc();
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if ({state, illegal} !== {S_FETCH, 1'b0}) begin
      n_err++; $display("FAIL halt_reset: got st=%0d ill=%b want st=0 ill=0", state, illegal);
    end
  endtask

  task automatic test_reset_mem_wr();
    logic [3:0] exp_st [5];
    logic       mr     [5];
    exp_st = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_WR, S_MEM_WR};
    mr     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    opcode = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = mr[i];
      #1;
      n_cmp++;
      if (state !== exp_st[i]) begin
        n_err++; $display("FAIL rstwr_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
      end
      if (i < 4) cyc();
    end
    n_cmp++;
    if (mem_we !== 1'b1) begin
      n_err++; $display("FAIL rstwr_wait_we: got %b want 1", mem_we);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({mem_we, regwrite} !== 2'b00) begin
      n_err++; $display("FAIL rstwr_reset_cycle: got %b want 00", {mem_we, regwrite});
    end
    cyc();
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({state, mem_we, pc_write, ir_write, regwrite} !== {S_FETCH, 4'b0000}) begin
      n_err++; $display("FAIL rstwr_after: got st=%0d we=%b pc=%b ir=%b rw=%b want st=0 0 0 0 0",
                        state, mem_we, pc_write, ir_write, regwrite);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw();
    test_andi();
    test_beq();
    test_ext_branch(6'b101101, 6'b111101);
    test_ext_branch(6'b100001, 6'b111011);
    test_halt();
    test_reset_mem_wr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high; sampled on rising clk edge.
REQ-003 SHALL have port: opcode  input  6  instruction[31:26] from the instruction register.
REQ-004 SHALL have port: mem_ready  input  1  memory completes the current access this cycle.
REQ-005 SHALL have ports, all outputs, 1 bit unless stated: pc_write, pc_write_cond, ir_write, iord, mem_req, mem_we, alusrca, alusrcb(2), aluop(2), regdst, memtoreg, regwrite, pcsource(2), link, reg_31, b_invert, balv_s, illegal.
REQ-006 SHALL have port: state  output  4  current FSM state encoding, for debug.

Function
REQ-007 SHALL be a Moore FSM; every output SHALL be a function of the registered state only, except mem_ready-qualified strobes (REQ-010).
REQ-008 SHALL have states: FETCH, DECODE, EXEC_R, R_WB, EXEC_I, I_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, HALT.
REQ-009 FETCH SHALL drive mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00.
REQ-010 In FETCH, ir_write and pc_write SHALL assert only in the cycle mem_ready=1; the FSM SHALL stay in FETCH while mem_ready=0.
REQ-011 DECODE SHALL drive alusrca=0, alusrcb=11, aluop=00 (branch target precompute), then branch on opcode.
REQ-012 DECODE transitions: 000000->EXEC_R; 100011/101011->MEM_ADDR; 000100->BRANCH; 001100->EXEC_I; 101101/100001->BRANCH (see REQ-024); any other opcode->HALT.
REQ-013 EXEC_R: alusrca=1, alusrcb=00, aluop=10; next R_WB. R_WB: regdst=1, memtoreg=0, regwrite=1; next FETCH.
REQ-014 EXEC_I: alusrca=1, alusrcb=10, aluop=11; next I_WB. I_WB: regdst=0, memtoreg=0, regwrite=1; next FETCH.
REQ-015 MEM_ADDR: alusrca=1, alusrcb=10, aluop=00; next MEM_RD if opcode=100011, else MEM_WR.
REQ-016 MEM_RD: mem_req=1, iord=1, mem_we=0; hold until mem_ready=1, then MEM_WB. MEM_WB: regdst=0, memtoreg=1, regwrite=1; next FETCH.
REQ-017 MEM_WR: mem_req=1, iord=1, mem_we=1; hold until mem_ready=1, then FETCH.
REQ-018 BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsource=01, pc_write_cond=1; next FETCH.
REQ-019 HALT: illegal=1, all other strobes 0; SHALL remain in HALT until reset.
REQ-020 Opcode SHALL be sampled only in DECODE and MEM_ADDR; opcode changes in other states SHALL have no effect.
REQ-021 Latency with mem_ready tied high: R 4, andi 4, lw 5, sw 4, beq 3, bneal/balv 3 cycles; each memory wait cycle adds exactly 1.
REQ-022 Outputs not listed for a state SHALL be 0 in that state; mem_we SHALL never assert without mem_req.

Reset
REQ-023 On reset=1 at a clock edge, state SHALL become FETCH regardless of current state (including HALT and memory waits); during the reset cycle and the first FETCH cycle after it, regwrite, mem_we, pc_write, pc_write_cond and ir_write SHALL be 0 until mem_ready qualifies FETCH.

Configuration
REQ-024 Macro EXT_BRANCH_EN defined: in BRANCH, bneal (101101) SHALL add link=1, reg_31=1, regwrite=1, b_invert=1; balv (100001) SHALL add link=1, reg_31=1, regwrite=1, balv_s=1; opcode latched in DECODE selects the variant.
REQ-025 EXT_BRANCH_EN undefined: 101101 and 100001 SHALL decode to HALT; link, reg_31, b_invert, balv_s SHALL be tied 0.

Structure
REQ-026 Opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ANDI, OP_BNEAL, OP_BALV), ALUOP codes and the state enumeration SHALL live in shared package mc_pkg.
REQ-027 Output decode per state SHALL be a sub-module mc_out_decode (state, latched opcode, mem_ready -> strobes); next-state logic and state register stay in the top.

Verification
REQ-028 reset, then opcode=000000, mem_ready=1 -> states FETCH,DECODE,EXEC_R,R_WB,FETCH; regwrite=1 only in R_WB, regdst=1.
REQ-029 opcode=100011, mem_ready low 2 cycles in MEM_RD -> MEM_RD held 3 cycles, mem_req=1,iord=1 throughout, then MEM_WB memtoreg=1 regwrite=1; total 7 cycles.
REQ-030 opcode=101011, mem_ready=1 -> MEM_WR one cycle with mem_we=1, regwrite never asserted, back to FETCH after 4 cycles.
REQ-031 opcode=101101 with EXT_BRANCH_EN -> BRANCH with pc_write_cond=1, link=1, reg_31=1, b_invert=1, regwrite=1; without macro -> HALT, illegal=1 held.
REQ-032 opcode=111111 -> HALT, illegal=1 for 10 cycles; reset asserted -> next state FETCH, illegal=0.
REQ-033 reset asserted during MEM_WR wait (mem_ready=0) -> next cycle FETCH, mem_we=0, no write strobe.
